// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: 2-flop sync, per-channel bounce filter, press/release pulses,
// long-press detection with optional auto-repeat.
module key_debounce_multi #(
   parameter int unsigned N_KEYS          = 4,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_pressed,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic              key_event
);

   localparam int unsigned DebW    = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HoldW   = (HoldMax > 0) ? $clog2(HoldMax + 1) : 1;
   localparam logic [N_KEYS-1:0] RelPin = {N_KEYS{ACTIVE_LOW}};

   typedef enum logic [1:0] {StIdle, StHeld, StRepeat} hold_st_e;

   logic [N_KEYS-1:0] sync1_q, sync2_q, raw;
   logic [N_KEYS-1:0] stable_q, stable_d;
   logic [DebW-1:0]   deb_cnt_q  [N_KEYS];
   logic [DebW-1:0]   deb_cnt_d  [N_KEYS];
   logic [HoldW-1:0]  hold_cnt_q [N_KEYS];
   logic [HoldW-1:0]  hold_cnt_d [N_KEYS];
   hold_st_e          state_q    [N_KEYS];
   hold_st_e          state_d    [N_KEYS];
   logic [N_KEYS-1:0] press_q, press_d, release_q, release_d, long_q, long_d;
   logic              key_event_q, key_event_d;

   assign raw = sync2_q ^ RelPin;

   // Bounce filter: accept raw only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         stable_d[i]  = stable_q[i];
         deb_cnt_d[i] = '0;
         press_d[i]   = 1'b0;
         release_d[i] = 1'b0;
         if (raw[i] != stable_q[i]) begin
            if (32'(deb_cnt_q[i]) + 32'd1 >= DEBOUNCE_CYCLES) begin
               stable_d[i]  = raw[i];
               press_d[i]   = raw[i];
               release_d[i] = ~raw[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
         end
      end
   end

   // Hold tracking keys off stable_d so a release on a threshold cycle suppresses long_pulse.
   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         state_d[i]    = state_q[i];
         hold_cnt_d[i] = hold_cnt_q[i];
         long_d[i]     = 1'b0;
         unique case (state_q[i])
            StIdle: begin
               hold_cnt_d[i] = '0;
               if (stable_d[i]) state_d[i] = StHeld;
            end
            StHeld: begin
               if (!stable_d[i]) begin
                  state_d[i]    = StIdle;
                  hold_cnt_d[i] = '0;
               end else if (LONG_CYCLES == 0) begin
                  if (hold_cnt_q[i] != '1) hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
               end else if (32'(hold_cnt_q[i]) + 32'd1 >= LONG_CYCLES) begin
                  state_d[i]    = StRepeat;
                  hold_cnt_d[i] = '0;
                  long_d[i]     = 1'b1;
               end else begin
                  hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
               end
            end
            StRepeat: begin
               if (!stable_d[i]) begin
                  state_d[i]    = StIdle;
                  hold_cnt_d[i] = '0;
               end else if (REPEAT_CYCLES == 0) begin
                  hold_cnt_d[i] = hold_cnt_q[i];
               end else if (32'(hold_cnt_q[i]) + 32'd1 >= REPEAT_CYCLES) begin
                  hold_cnt_d[i] = '0;
                  long_d[i]     = 1'b1;
               end else begin
                  hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
               end
            end
            default: begin
               state_d[i]    = StIdle;
               hold_cnt_d[i] = '0;
            end
         endcase
      end
   end

   assign key_event_d = (|press_d) | (|release_d) | (|long_d);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_q     <= RelPin;
         sync2_q     <= RelPin;
         stable_q    <= '0;
         press_q     <= '0;
         release_q   <= '0;
         long_q      <= '0;
         key_event_q <= 1'b0;
         for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_q[i]  <= '0;
            hold_cnt_q[i] <= '0;
            state_q[i]    <= StIdle;
         end
      end else begin
         sync1_q     <= key_in;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         key_event_q <= key_event_d;
         for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_q[i]  <= deb_cnt_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
            state_q[i]    <= state_d[i];
         end
      end
   end

   assign key_pressed   = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign key_event     = key_event_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: active-low instance with long/repeat, and an active-high
// instance with long press disabled, both compared each cycle against a timestamp model.
module tb_key_debounce_multi;

   localparam int D  = 8;
   localparam int LA = 32;
   localparam int R  = 16;

   logic       clk, rst;
   logic [3:0] key_a, key_b;
   logic [3:0] kp_a, pr_a, rl_a, lg_a, kp_b, pr_b, rl_b, lg_b;
   logic       ev_a, ev_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int long_cnt_a2 = 0;
   int long_cnt_b = 0;

   // Model state, channels 0-3 = instance a, 4-7 = instance b
   logic [1:0]  m_pipe [8];
   logic [15:0] m_hist [8];
   int          m_nv   [8];
   logic        m_st   [8];
   int          m_p    [8];
   logic [7:0]  e_kp, e_pr, e_rl, e_lg;

   key_debounce_multi #(
      .N_KEYS(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16)
   ) dut_a (
      .sys_clk(clk), .sys_rst(rst), .key_in(key_a), .key_pressed(kp_a), .press_pulse(pr_a),
      .release_pulse(rl_a), .long_pulse(lg_a), .key_event(ev_a)
   );

   key_debounce_multi #(
      .N_KEYS(4), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(0), .REPEAT_CYCLES(16)
   ) dut_b (
      .sys_clk(clk), .sys_rst(rst), .key_in(key_b), .key_pressed(kp_b), .press_pulse(pr_b),
      .release_pulse(rl_b), .long_pulse(lg_b), .key_event(ev_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic al(input int c);
      return (c < 4) ? 1'b1 : 1'b0;
   endfunction

   function automatic int long_th(input int c);
      return (c < 4) ? LA : 0;
   endfunction

   task automatic model_reset();
      cyc++;
      for (int c = 0; c < 8; c++) begin
         m_pipe[c] = {al(c), al(c)};
         m_hist[c] = '0;
         m_nv[c]   = 0;
         m_st[c]   = 1'b0;
         m_p[c]    = 0;
      end
      e_kp = '0; e_pr = '0; e_rl = '0; e_lg = '0;
   endtask

   // Pin reaches the filter two edges later; a change is accepted once the last D
   // filtered samples all differ from the accepted level. Long pulses fall at
   // press_time + LONG + k*REPEAT while still held.
   task automatic model_step();
      logic pin, pr, acc;
      logic [D-1:0] w;
      int d, lt;
      cyc++;
      for (int c = 0; c < 8; c++) begin
         pin = (c < 4) ? key_a[c] : key_b[c-4];
         pr = m_pipe[c][1] ^ al(c);
         m_pipe[c] = {m_pipe[c][0], pin};
         m_hist[c] = {m_hist[c][14:0], pr};
         if (m_nv[c] < 1000) m_nv[c]++;
         w = m_hist[c][D-1:0];
         acc = (m_nv[c] >= D) && (w == {D{~m_st[c]}});
         e_pr[c] = acc && !m_st[c];
         e_rl[c] = acc && m_st[c];
         if (acc) begin
            m_st[c] = ~m_st[c];
            if (m_st[c]) m_p[c] = cyc;
         end
         e_kp[c] = m_st[c];
         d  = cyc - m_p[c];
         lt = long_th(c);
         e_lg[c] = m_st[c] && !e_pr[c] && (lt > 0) &&
                   ((d == lt) || (R > 0 && d > lt && ((d - lt) % R) == 0));
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      chk("a_key_pressed", 32'(kp_a), 32'(e_kp[3:0]));
      chk("a_press", 32'(pr_a), 32'(e_pr[3:0]));
      chk("a_release", 32'(rl_a), 32'(e_rl[3:0]));
      chk("a_long", 32'(lg_a), 32'(e_lg[3:0]));
      chk("a_event", 32'(ev_a), 32'(|{e_pr[3:0], e_rl[3:0], e_lg[3:0]}));
      chk("b_key_pressed", 32'(kp_b), 32'(e_kp[7:4]));
      chk("b_press", 32'(pr_b), 32'(e_pr[7:4]));
      chk("b_release", 32'(rl_b), 32'(e_rl[7:4]));
      chk("b_long", 32'(lg_b), 32'(e_lg[7:4]));
      chk("b_event", 32'(ev_b), 32'(|{e_pr[7:4], e_rl[7:4], e_lg[7:4]}));
      if (lg_a[2]) long_cnt_a2++;
      if (|lg_b) long_cnt_b++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      rst   = 1'b1;
      key_a = 4'hF;
      key_b = 4'h0;
      ticks(3);
      chk("reset_outputs", 32'({kp_a, pr_a, rl_a, lg_a, ev_a}), 32'd0);
      rst = 1'b0;
      ticks(12);

      // Clean press on a[0]: 10 edges of latency
      key_a[0] = 1'b0;
      ticks(9);
      chk("t1_not_yet", 32'(kp_a[0]), 32'd0);
      tick();
      chk("t1_press", 32'(pr_a[0]), 32'd1);
      chk("t1_event", 32'(ev_a), 32'd1);
      tick();
      chk("t1_press_width", 32'(pr_a[0]), 32'd0);
      chk("t1_level", 32'(kp_a[0]), 32'd1);
      key_a[0] = 1'b1;
      ticks(15);

      // Bounce on a[1] shorter than the filter window
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) key_a[1] = ~key_a[1];
         tick();
      end
      key_a[1] = 1'b1;
      ticks(15);
      chk("t2_no_press", 32'(kp_a[1]), 32'd0);

      // Long hold on a[2]: long at +42 and repeats at +58, +74, +90
      long_cnt_a2 = 0;
      key_a[2] = 1'b0;
      ticks(100);
      chk("t3_long_count", 32'(long_cnt_a2), 32'd4);
      key_a[2] = 1'b1;
      ticks(9);
      chk("t3_still_held", 32'(kp_a[2]), 32'd1);
      tick();
      chk("t3_release", 32'(rl_a[2]), 32'd1);
      ticks(15);

      // Simultaneous press on a[0] and a[3]
      key_a[0] = 1'b0;
      key_a[3] = 1'b0;
      ticks(10);
      chk("t4_press_both", 32'(pr_a), 32'h9);
      chk("t4_event", 32'(ev_a), 32'd1);
      tick();
      chk("t4_event_width", 32'(ev_a), 32'd0);
      key_a[0] = 1'b1;
      key_a[3] = 1'b1;
      ticks(15);

      // Reset while a[1] held: re-debounced as a fresh press after reset
      key_a[1] = 1'b0;
      ticks(20);
      rst = 1'b1;
      ticks(3);
      chk("t5_reset_level", 32'(kp_a), 32'd0);
      rst = 1'b0;
      ticks(9);
      chk("t5_no_exit_pulse", 32'(kp_a[1]), 32'd0);
      tick();
      chk("t5_press", 32'(pr_a[1]), 32'd1);
      key_a[1] = 1'b1;
      ticks(15);

      // Active-high instance with long press disabled
      long_cnt_b = 0;
      key_b[0] = 1'b1;
      ticks(10);
      chk("t6_press", 32'(pr_b[0]), 32'd1);
      ticks(80);
      chk("t6_no_long", 32'(long_cnt_b), 32'd0);
      key_b[0] = 1'b0;
      ticks(15);

      // Random pin activity on both instances with occasional resets
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(39, 0) == 0) key_a[c] = ~key_a[c];
            if ($urandom_range(39, 0) == 0) key_b[c] = ~key_b[c];
         end
         if (rst) rst = 1'b0;
         else if ($urandom_range(999, 0) == 0) rst = 1'b1;
         tick();
      end
      chk("rand_b_no_long", 32'(long_cnt_b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
